// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, WIDTH data bits LSB first, 1 stop bit, idle high.
// Mid-bit sampling, one-entry output register with valid/read handshake,
// framing-error pulse and sticky overrun flag.
`timescale 1ns/1ps

module uart_rx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      clock_divider,
    input  logic             rx,
    input  logic             read_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             framing_error,
    output logic             overrun
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    logic             rx_meta_q;
    logic             rxs_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             fe_q, fe_d;
    logic             ovr_q, ovr_d;

    assign data_out      = data_q;
    assign data_valid    = valid_q;
    assign framing_error = fe_q;
    assign overrun       = ovr_q;

    // Two-flop synchronizer for the asynchronous serial line, idles high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame FSM plus delivery/read handling of the output register.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        fe_d    = 1'b0;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                    div_d   = clock_divider;
                end
            end
            S_START: begin
                // Confirm the start bit at its centre; a high line is a glitch.
                if (cnt_q == (div_q >> 1)) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == div_q) begin
                    cnt_d          = '0;
                    shift_d        = shift_q >> 1;
                    shift_d[WIDTH-1] = rxs_q;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(WIDTH - 1)) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == div_q) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // Hold off through a break so a low line cannot retrigger frames.
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        if (done_q) begin
            if (!valid_q) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else if (read_en) begin
                data_d = shift_q;
                ovr_d  = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (read_en && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

endmodule
